// File: rtl/cgr_kmer_reader_pkg.sv
// rtl/cgr_kmer_reader_pkg.sv - shared CGR types, symbol encoding and address packing
package cgr_pkg;

    localparam int CGR_DATA_LEN = 3;
    // Widest k-mer the packing helper supports; callers cast the result down.
    localparam int CGR_MAX_DL   = 16;

    // 2-bit symbol encoding {a,b}: a from the x coordinate bit, b from the y bit.
    localparam logic [1:0] SYM_A = 2'b00;
    localparam logic [1:0] SYM_C = 2'b01;
    localparam logic [1:0] SYM_G = 2'b10;
    localparam logic [1:0] SYM_T = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } cgr_state_e;

    // Memory address {x, 1'b0, y}; the same packing the CGR writer uses.
    function automatic logic [2*CGR_MAX_DL:0] cgr_pack_xy(
        input logic [CGR_MAX_DL-1:0] x,
        input logic [CGR_MAX_DL-1:0] y,
        input int unsigned           dlen
    );
        logic [2*CGR_MAX_DL:0] xe;
        logic [2*CGR_MAX_DL:0] ye;
        xe = {{(CGR_MAX_DL+1){1'b0}}, x};
        ye = {{(CGR_MAX_DL+1){1'b0}}, y};
        return (xe << (dlen + 1)) | ye;
    endfunction

    function automatic logic [1:0] cgr_sym(input logic a, input logic b);
        return {a, b};
    endfunction

endpackage

// File: rtl/cgr_kmer_reader_if.sv
// rtl/cgr_kmer_reader_if.sv - CGR memory read port and k-mer symbol stream
interface cgr_kmer_reader_if #(
    parameter int DATA_LEN = 3,
    parameter int CNT_W    = 16
);
    logic                  mem_ren;
    logic [2*DATA_LEN:0]   mem_raddr;
    logic [CNT_W-1:0]      mem_rdata;
    logic                  sym_valid;
    logic                  sym_ready;
    logic [1:0]            symbol;
    logic                  sym_last;
    logic [CNT_W-1:0]      kmer_count;

    // Reader side: drives the memory request and the symbol stream.
    modport master (
        output mem_ren, mem_raddr,
        input  mem_rdata,
        output sym_valid, symbol, sym_last, kmer_count,
        input  sym_ready
    );

    // Memory and downstream consumer side.
    modport slave (
        input  mem_ren, mem_raddr,
        output mem_rdata,
        input  sym_valid, symbol, sym_last, kmer_count,
        output sym_ready
    );
endinterface

// File: rtl/cgr_kmer_reader_ser.sv
// rtl/cgr_kmer_reader_ser.sv - parallel-load k-mer serializer with valid/ready and last
module cgr_kmer_ser
    import cgr_pkg::*;
#(
    parameter int DATA_LEN = CGR_DATA_LEN,
    parameter int CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [DATA_LEN-1:0] x_i,
    input  logic [DATA_LEN-1:0] y_i,
    input  logic [CNT_W-1:0]    cnt_i,
    input  logic                sym_ready_i,
    output logic                sym_valid_o,
    output logic [1:0]          symbol_o,
    output logic                sym_last_o,
    output logic [CNT_W-1:0]    kmer_count_o,
    output logic                last_hs_o
);
    localparam int POS_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(DATA_LEN - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    logic [DATA_LEN-1:0] x_q, x_d;
    logic [DATA_LEN-1:0] y_q, y_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                valid_q, valid_d;
    logic                hs;
    logic                is_last;

    assign hs      = valid_q & sym_ready_i;
    assign is_last = valid_q && (pos_q == POS_LAST);

    // Bit 0 always holds the oldest pending symbol, so outputs come straight off the LSBs.
    assign sym_valid_o  = valid_q;
    assign symbol_o     = valid_q ? cgr_sym(x_q[0], y_q[0]) : 2'b00;
    assign sym_last_o   = is_last;
    assign kmer_count_o = cnt_q;
    assign last_hs_o    = hs & is_last;

    // Next state: parallel load wins, otherwise shift one symbol per handshake.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        valid_d = valid_q;
        if (load_i) begin
            x_d     = x_i;
            y_d     = y_i;
            cnt_d   = cnt_i;
            pos_d   = '0;
            valid_d = 1'b1;
        end else if (hs) begin
            x_d = x_q >> 1;
            y_d = y_q >> 1;
            if (is_last) begin
                pos_d   = '0;
                valid_d = 1'b0;
            end else begin
                pos_d = pos_q + POS_ONE;
            end
        end
    end

    // Serializer registers; reset abandons any partial k-mer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/cgr_kmer_reader.sv
// rtl/cgr_kmer_reader.sv - CGR count memory sweep and k-mer readout (option: CGR_READER_SKIP_ZERO_EN)
module cgr_kmer_reader
    import cgr_pkg::*;
#(
    parameter int DATA_LEN = CGR_DATA_LEN,
    parameter int CNT_W    = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    output logic               busy,
    output logic               done,
    cgr_kmer_reader_if.master  bus
);
    localparam int IDX_W = 2 * DATA_LEN;
    localparam logic [IDX_W-1:0] IDX_MAX = '1;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    cgr_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_LEN-1:0] x_w;
    logic [DATA_LEN-1:0] y_w;
    logic                load;
    logic                last_hs;

    assign x_w = idx_q[IDX_W-1:DATA_LEN];
    assign y_w = idx_q[DATA_LEN-1:0];

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign bus.mem_ren   = (state_q == READ);
    assign bus.mem_raddr = (2*DATA_LEN+1)'(cgr_pack_xy(CGR_MAX_DL'(x_w), CGR_MAX_DL'(y_w), DATA_LEN));

    // Sweep sequencing: one read, one capture cycle, then the serializer owns the cycle count.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
`ifdef CGR_READER_SKIP_ZERO_EN
                if (bus.mem_rdata == '0) begin
                    if (idx_q == IDX_MAX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = READ;
                    end
                end else begin
                    load    = 1'b1;
                    state_d = EMIT;
                end
`else
                load    = 1'b1;
                state_d = EMIT;
`endif
            end
            EMIT: begin
                if (last_hs) begin
                    if (idx_q == IDX_MAX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                // idx wraps here and only here, ready for the next sweep.
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and sweep index registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    cgr_kmer_ser #(
        .DATA_LEN (DATA_LEN),
        .CNT_W    (CNT_W)
    ) u_ser (
        .clk_i        (CLK),
        .rst_ni       (RST_N),
        .load_i       (load),
        .x_i          (x_w),
        .y_i          (y_w),
        .cnt_i        (bus.mem_rdata),
        .sym_ready_i  (bus.sym_ready),
        .sym_valid_o  (bus.sym_valid),
        .symbol_o     (bus.symbol),
        .sym_last_o   (bus.sym_last),
        .kmer_count_o (bus.kmer_count),
        .last_hs_o    (last_hs)
    );

endmodule

// File: tb/tb_cgr_kmer_reader.sv
// tb/tb_cgr_kmer_reader.sv - self-checking bench for cgr_kmer_reader
module tb_cgr_kmer_reader;
    import cgr_pkg::*;

    typedef struct {
        int          idx;
        logic [6:0]  raddr;
        logic [15:0] cnt;
        logic [1:0]  s0;
        logic [1:0]  s1;
        logic [1:0]  s2;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    cgr_kmer_reader_if #(.DATA_LEN(3), .CNT_W(16)) bus ();

    cgr_kmer_reader #(.DATA_LEN(3), .CNT_W(16)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    logic [15:0] mem [128];

    always @(posedge clk) begin
        if (!rst_n)
            bus.mem_rdata <= 16'd0;
        else if (bus.mem_ren)
            bus.mem_rdata <= mem[bus.mem_raddr];
    end

    int checks = 0;
    int errors = 0;

    vec_t tbl [7];

    logic [6:0]  cap_raddr [64];
    logic [15:0] cap_cnt   [64];
    logic [1:0]  cap_sym   [64][3];
    int rd_cnt, kcnt, pos, sym_total, done_cnt, done_n, first_ren_n, first_val_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},       busy, 0);
        chk({tag, "_done"},       done, 0);
        chk({tag, "_mem_ren"},    bus.mem_ren, 0);
        chk({tag, "_mem_raddr"},  bus.mem_raddr, 0);
        chk({tag, "_sym_valid"},  bus.sym_valid, 0);
        chk({tag, "_symbol"},     bus.symbol, 0);
        chk({tag, "_sym_last"},   bus.sym_last, 0);
        chk({tag, "_kmer_count"}, bus.kmer_count, 0);
    endtask

    task automatic run_sweep(input int stall_kmer, input int stall_len);
        int n;
        int stall_left;
        bit stalled;
        bit finished;
        logic [1:0]  h_sym;
        logic        h_last;
        logic [15:0] h_cnt;
        rd_cnt = 0; kcnt = 0; pos = 0; sym_total = 0;
        done_cnt = 0; done_n = 0; first_ren_n = 0; first_val_n = 0;
        n = 0; stall_left = 0; stalled = 0; finished = 0;
        h_sym = 0; h_last = 0; h_cnt = 0;
        bus.sym_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        while (!finished && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1)  start = 1'b0;
            if (n == 50) start = 1'b1;
            if (n == 51) start = 1'b0;
            if (bus.mem_ren) begin
                if (first_ren_n == 0) first_ren_n = n;
                if (rd_cnt < 64) cap_raddr[rd_cnt] = bus.mem_raddr;
                rd_cnt++;
                chk("ren_during_emit", bus.sym_valid, 0);
            end
            if (bus.sym_valid) begin
                if (first_val_n == 0) first_val_n = n;
                if (!stalled && kcnt == stall_kmer && pos == 1) begin
                    stalled = 1;
                    h_sym = bus.symbol; h_last = bus.sym_last; h_cnt = bus.kmer_count;
                    stall_left = stall_len;
                    bus.sym_ready = 1'b0;
                end else begin
                    if (stall_left > 0) begin
                        chk("stall_symbol", bus.symbol, h_sym);
                        chk("stall_last",   bus.sym_last, h_last);
                        chk("stall_count",  bus.kmer_count, h_cnt);
                        chk("stall_no_ren", bus.mem_ren, 0);
                        stall_left--;
                        if (stall_left == 0) bus.sym_ready = 1'b1;
                    end
                    if (bus.sym_ready) begin
                        if (kcnt < 64) begin
                            cap_sym[kcnt][pos] = bus.symbol;
                            if (pos == 0) cap_cnt[kcnt] = bus.kmer_count;
                            else chk("count_stable", bus.kmer_count, cap_cnt[kcnt]);
                        end
                        chk("sym_last", bus.sym_last, (pos == 2));
                        sym_total++;
                        pos++;
                        if (pos == 3) begin
                            pos = 0;
                            kcnt++;
                        end
                    end
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_with_done", busy, 1);
                done_n = n;
                start = 1'b1;
                finished = 1;
            end
        end
        if (!finished) chk("sweep_timeout", n, 0);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_done", busy, 0);
        chk("done_single", done, 0);
        repeat (3) begin
            @(negedge clk);
            if (busy || bus.mem_ren) chk("no_restart", {busy, bus.mem_ren}, 0);
        end
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("%s_tbl%0d_raddr", tag, i), cap_raddr[tbl[i].idx], tbl[i].raddr);
            chk($sformatf("%s_tbl%0d_count", tag, i), cap_cnt[tbl[i].idx], tbl[i].cnt);
            chk($sformatf("%s_tbl%0d_s0", tag, i), cap_sym[tbl[i].idx][0], tbl[i].s0);
            chk($sformatf("%s_tbl%0d_s1", tag, i), cap_sym[tbl[i].idx][1], tbl[i].s1);
            chk($sformatf("%s_tbl%0d_s2", tag, i), cap_sym[tbl[i].idx][2], tbl[i].s2);
        end
    endtask

    task automatic check_counts(input string tag, input int exp_done_n);
        chk({tag, "_done_n"},    done_n, exp_done_n);
        chk({tag, "_done_cnt"},  done_cnt, 1);
        chk({tag, "_first_ren"}, first_ren_n, 1);
        chk({tag, "_first_val"}, first_val_n, 3);
        chk({tag, "_kmers"},     kcnt, 64);
        chk({tag, "_symbols"},   sym_total, 192);
        chk({tag, "_reads"},     rd_cnt, 64);
    endtask

    initial begin
        logic [5:0] iv;
        tbl[0] = '{0,  7'h00, 16'd100, SYM_A, SYM_A, SYM_A};
        tbl[1] = '{1,  7'h01, 16'd101, SYM_C, SYM_A, SYM_A};
        tbl[2] = '{7,  7'h07, 16'd107, SYM_C, SYM_C, SYM_C};
        tbl[3] = '{10, 7'h12, 16'd118, SYM_G, SYM_C, SYM_A};
        tbl[4] = '{29, 7'h35, 16'd9,   SYM_T, SYM_G, SYM_C};
        tbl[5] = '{32, 7'h40, 16'd164, SYM_A, SYM_A, SYM_G};
        tbl[6] = '{63, 7'h77, 16'd219, SYM_T, SYM_T, SYM_T};

        bus.sym_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

`ifdef CGR_READER_SKIP_ZERO_EN
        for (int a = 0; a < 128; a++) mem[a] = 16'd0;
        mem[7'h35] = 16'd4;
        run_sweep(-1, 0);
        chk("skip_kmers",   kcnt, 1);
        chk("skip_symbols", sym_total, 3);
        chk("skip_reads",   rd_cnt, 64);
        chk("skip_done_n",  done_n, 132);
        chk("skip_count",   cap_cnt[0], 16'd4);
        chk("skip_s0",      cap_sym[0][0], SYM_T);
        chk("skip_s1",      cap_sym[0][1], SYM_G);
        chk("skip_s2",      cap_sym[0][2], SYM_C);
`else
        for (int a = 0; a < 128; a++) mem[a] = 16'(100 + a);
        mem[7'h35] = 16'd9;

        // Reset during the second symbol of the first k-mer.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_emit_valid", bus.sym_valid, 1);
        chk("mid_emit_pos1_symbol", bus.symbol, SYM_A);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("rst_mid");
        rst_n = 1'b1;

        run_sweep(-1, 0);
        check_counts("sweepA", 321);
        chk("sweepA_first_addr", cap_raddr[0], 7'h00);
        for (int i = 0; i < 64; i++) begin
            iv = i[5:0];
            if (cap_raddr[i] !== {iv[5:3], 1'b0, iv[2:0]})
                chk($sformatf("sweepA_addr%0d", i), cap_raddr[i], {iv[5:3], 1'b0, iv[2:0]});
        end
        check_table("sweepA");

        for (int i = 0; i < 64; i++) cap_cnt[i] = 16'hxxxx;
        run_sweep(1, 5);
        check_counts("sweepB", 326);
        check_table("sweepB");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cgr_kmer_reader.md
# cgr_kmer_reader

Reads back the chaos-game-representation (CGR) count memory filled by the CGR address generator. It sweeps every k-mer address, fetches each count and decodes the address into its DNA symbol sequence. The result streams out serially over a valid/ready interface for the downstream k-mer reporting stage. It is the read side of the CGR memory: it consumes the same address packing and the same 2-bit symbol encoding the writer produces.

## Interface
Parameters:
- DATA_LEN, 3, k-mer length; symbols per address; x and y coordinates are each DATA_LEN bits
- CNT_W, 16, width of one count word in the CGR memory

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, synchronous, active-low (sampled on rising CLK edge)
- start  in  1  one-cycle request to begin a full sweep; ignored while busy
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last k-mer has been emitted
- mem_ren  out  1  memory read enable
- mem_raddr  out  2*DATA_LEN+1  read address {x, 1'b0, y}
- mem_rdata  in  CNT_W  count word, valid exactly one cycle after mem_ren
- sym_valid  out  1  symbol output valid
- sym_ready  in  1  downstream accepts symbol
- symbol  out  2  decoded symbol {a,b}, a from x bit, b from y bit
- sym_last  out  1  marks the final symbol of the current k-mer
- kmer_count  out  CNT_W  count of the k-mer being emitted; stable for all of its symbols

## Operation
- Sweep index idx, 2*DATA_LEN bits: x = idx[2*DATA_LEN-1:DATA_LEN], y = idx[DATA_LEN-1:0]. idx runs 0 … 4^DATA_LEN−1 in order.
- Address packing: mem_raddr = {x, 1'b0, y}. The middle bit is always 0.
- FSM states: IDLE, READ, WAIT, EMIT, DONE.
  - IDLE: start=1 → idx=0, go to READ.
  - READ: mem_ren=1 for exactly one cycle, then go to WAIT.
  - WAIT: capture mem_rdata into kmer_count, set pos=0, go to EMIT (see Configuration for zero skipping).
  - EMIT: sym_valid=1 and symbol={x[pos], y[pos]}.
    - Bit 0 is the oldest symbol, so symbols leave in sequence order.
    - On sym_valid&sym_ready: pos++.
    - sym_last=1 when pos==DATA_LEN−1.
    - On the handshake of the last symbol: if idx==4^DATA_LEN−1 go to DONE, else idx++ and go to READ.
  - DONE: done=1 for one cycle, then go to IDLE.
- Output stability: while sym_valid=1 and sym_ready=0, symbol, sym_last and kmer_count hold stable. sym_valid never drops before its handshake.
- start while not in IDLE: ignored. start in the DONE cycle: also ignored.
- Arithmetic: idx wraps only via the DONE exit, never silently. pos counts 0 … DATA_LEN−1.

## Timing
- Reset (RST_N=0 at an edge), including mid-sweep: state=IDLE, idx=0, pos=0. Every output is 0: busy, done, mem_ren, mem_raddr, sym_valid, symbol, sym_last, kmer_count. Any partial k-mer is abandoned.
- Start sampled at edge T: READ (mem_ren=1) in cycle T+1, WAIT in T+2, first sym_valid in T+3.
- Per k-mer with sym_ready held high: 2+DATA_LEN cycles.
- Full sweep with sym_ready held high: 4^DATA_LEN·(2+DATA_LEN) cycles, then the done pulse. For DATA_LEN=3 that is 320 cycles, with done in cycle T+321.
- busy=1 in all states except IDLE.
- No read is issued while a k-mer is being emitted; at most one read is outstanding.

## Configuration
- CGR_READER_SKIP_ZERO_EN defined: in WAIT, a count of 0 emits nothing. Go directly to the next READ, or to DONE if idx is at max. Each zero entry costs 2 cycles.
- Not defined: every address is emitted, including count 0, so exactly 4^DATA_LEN k-mers appear per sweep.

## Structure
- Shared package cgr_pkg holds:
  - state enum (IDLE/READ/WAIT/EMIT/DONE)
  - DATA_LEN default
  - 2-bit symbol encoding constants
  - a function packing (x,y) into {x,1'b0,y}, shared with the CGR writer
- One sub-module, cgr_kmer_ser: loads x, y and count in parallel, then shifts symbols out under valid/ready with sym_last. The top-level FSM keeps idx and the memory port.

## Test plan
- Reset mid-EMIT (pulse RST_N low during the second symbol): next cycle all outputs 0 and state IDLE. A new start then re-sweeps from idx 0, mem_raddr=7'h00.
- Address decode, DATA_LEN=3, macro undefined, sym_ready=1: at idx=6'b011_101, mem_raddr=7'h35. Memory returns 9, so symbols 3,2,1 are emitted, sym_last is set on the third, and kmer_count=9 throughout.
- Backpressure: hold sym_ready=0 for 5 cycles on symbol 2. symbol, sym_last and kmer_count stay constant, no mem_ren is issued, and emission resumes correctly.
- Full sweep, DATA_LEN=3, sym_ready=1, macro undefined: 64 k-mers and 192 symbols are emitted. done pulses exactly once, 321 cycles after start is sampled. busy drops with done.
- CGR_READER_SKIP_ZERO_EN defined, memory all zero except address 7'h35=4: only symbols 3,2,1 are emitted, with kmer_count=4. done arrives 128+3 cycles after the first READ.
- start asserted while busy, and in the DONE cycle: no restart occurs and idx is unaffected.
